// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and requantisation helper for the systolic array
package systolic_pkg;

   localparam int DATA_W = 16;
   localparam int ACC_W  = 40;
   localparam int OUT_W  = 16;
   localparam int WIDE_W = 128;

   typedef logic signed [DATA_W-1:0] data_t;
   typedef logic signed [ACC_W-1:0]  acc_t;
   typedef logic signed [OUT_W-1:0]  out_t;

   typedef struct packed {
      logic signed [WIDE_W-1:0] value;
      logic                     sat;
   } sat_res_t;

   // Evaluated at WIDE_W so the rounding add can never wrap the accumulator.
   function automatic sat_res_t sat_round(input logic signed [WIDE_W-1:0] acc,
                                          input int frac_bits,
                                          input int out_width);
      logic signed [WIDE_W-1:0] one;
      logic signed [WIDE_W-1:0] r;
      logic signed [WIDE_W-1:0] hi;
      logic signed [WIDE_W-1:0] lo;
      sat_res_t res;
      one = WIDE_W'(1);
      r   = acc;
      if (frac_bits > 0) r = r + (one <<< (frac_bits - 1));
      r  = r >>> frac_bits;
      hi = (one <<< (out_width - 1)) - one;
      lo = -(one <<< (out_width - 1));
      res.sat = 1'b1;
      if (r > hi)      res.value = hi;
      else if (r < lo) res.value = lo;
      else begin
         res.value = r;
         res.sat   = 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/systolic_array_nxm_pe.sv
// rtl/systolic_array_nxm_pe.sv - weight-stationary PE with global stall
module pe_stall
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W,
   parameter int ACC_WIDTH  = ACC_W
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         adv,
   input  logic                         wr_en,
   input  logic signed [DATA_WIDTH-1:0] w_in,
   input  logic signed [DATA_WIDTH-1:0] data_i,
   input  logic                         valid_i,
   input  logic signed [ACC_WIDTH-1:0]  acc_i,
   output logic signed [DATA_WIDTH-1:0] data_o,
   output logic                         valid_o,
   output logic signed [ACC_WIDTH-1:0]  acc_o
);

   logic signed [DATA_WIDTH-1:0]   weight;
   logic signed [2*DATA_WIDTH-1:0] prod;

   assign prod = (2*DATA_WIDTH)'(weight) * (2*DATA_WIDTH)'(data_i);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         weight  <= '0;
         data_o  <= '0;
         valid_o <= 1'b0;
         acc_o   <= '0;
      end else begin
         if (wr_en) weight <= w_in;
         if (adv) begin
            data_o  <= data_i;
            valid_o <= valid_i;
            acc_o   <= acc_i + ACC_WIDTH'(prod);
         end
      end
   end

endmodule

// File: rtl/systolic_array_nxm.sv
// rtl/systolic_array_nxm.sv - parametrised ROWS x COLS weight-stationary systolic array
module systolic_array_nxm
   import systolic_pkg::*;
#(
   parameter  int ROWS       = 4,
   parameter  int COLS       = 4,
   parameter  int DATA_WIDTH = DATA_W,
   parameter  int ACC_WIDTH  = ACC_W,
   parameter  int OUT_WIDTH  = OUT_W,
   parameter  int FRAC_BITS  = 8,
   localparam int RW         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       w_valid,
   output logic                       w_ready,
   input  logic [RW-1:0]              w_row,
   input  logic [COLS*DATA_WIDTH-1:0] w_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [COLS*DATA_WIDTH-1:0] in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ROWS*OUT_WIDTH-1:0]  out_data,
   output logic [ROWS-1:0]            out_sat,
   output logic                       busy
);

   localparam int LATENCY = ROWS + COLS;
   localparam int CW      = $clog2(LATENCY + 1);

   logic                       adv;
   logic                       in_fire;
   logic                       w_fire;
   logic                       out_fire;
   logic [CW-1:0]              in_flight;
   logic [COLS*DATA_WIDTH-1:0] in_gated;

   assign adv      = !out_valid || out_ready;
   assign w_ready  = (in_flight == '0) && !out_valid;
   assign in_ready = adv && !w_valid && (in_flight < CW'(LATENCY));
   assign in_fire  = in_valid && in_ready;
   assign w_fire   = w_valid && w_ready;
   assign out_fire = out_valid && out_ready;
   assign busy     = (in_flight != '0);
   assign in_gated = in_fire ? in_data : '0;

   always_ff @(posedge clk) begin
      if (!rstn)                      in_flight <= '0;
      else if (in_fire && !out_fire)  in_flight <= in_flight + CW'(1);
      else if (!in_fire && out_fire)  in_flight <= in_flight - CW'(1);
   end

   // Vertical data/tag links (level r feeds PE row r) and horizontal partial sums.
   logic signed [DATA_WIDTH-1:0] dv [ROWS+1][COLS];
   logic                         vt [ROWS+1][COLS];
   logic signed [ACC_WIDTH-1:0]  ah [ROWS][COLS+1];

   for (genvar k = 0; k < COLS; k++) begin : g_skew
      logic [DATA_WIDTH:0] sk [k+1];
      always_ff @(posedge clk) begin
         if (!rstn) begin
            for (int j = 0; j <= k; j++) sk[j] <= '0;
         end else if (adv) begin
            sk[0] <= {in_fire, in_gated[k*DATA_WIDTH +: DATA_WIDTH]};
            for (int j = 1; j <= k; j++) sk[j] <= sk[j-1];
         end
      end
      assign vt[0][k] = sk[k][DATA_WIDTH];
      assign dv[0][k] = sk[k][DATA_WIDTH-1:0];
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign ah[r][0] = '0;
      for (genvar k = 0; k < COLS; k++) begin : g_col
         pe_stall #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
         ) u_pe (
            .clk     (clk),
            .rstn    (rstn),
            .adv     (adv),
            .wr_en   (w_fire && (w_row == RW'(r))),
            .w_in    (w_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .data_i  (dv[r][k]),
            .valid_i (vt[r][k]),
            .acc_i   (ah[r][k]),
            .data_o  (dv[r+1][k]),
            .valid_o (vt[r+1][k]),
            .acc_o   (ah[r][k+1])
         );
      end
   end

   // Row r finishes r cycles after row 0; delay earlier rows so all rows emit together.
   logic signed [ACC_WIDTH-1:0] row_acc [ROWS];
   logic [ROWS-1:0]             row_tag;

   for (genvar r = 0; r < ROWS; r++) begin : g_deskew
      localparam int D = ROWS - 1 - r;
      if (D == 0) begin : g_direct
         assign row_acc[r] = ah[r][COLS];
         assign row_tag[r] = vt[r+1][COLS-1];
      end else begin : g_delay
         logic [ACC_WIDTH:0] ds [D];
         always_ff @(posedge clk) begin
            if (!rstn) begin
               for (int j = 0; j < D; j++) ds[j] <= '0;
            end else if (adv) begin
               ds[0] <= {vt[r+1][COLS-1], ah[r][COLS]};
               for (int j = 1; j < D; j++) ds[j] <= ds[j-1];
            end
         end
         assign row_tag[r] = ds[D-1][ACC_WIDTH];
         assign row_acc[r] = ds[D-1][ACC_WIDTH-1:0];
      end
   end

   logic [ROWS*OUT_WIDTH-1:0]              rq_data;
   logic [ROWS-1:0]                        rq_sat;
   logic [ROWS-1:0][WIDE_W-OUT_WIDTH-1:0]  rq_hi;

   for (genvar r = 0; r < ROWS; r++) begin : g_rq
      sat_res_t res;
      assign res = sat_round(WIDE_W'(row_acc[r]), FRAC_BITS, OUT_WIDTH);
      assign rq_data[r*OUT_WIDTH +: OUT_WIDTH] = res.value[OUT_WIDTH-1:0];
      assign rq_sat[r] = res.sat;
      assign rq_hi[r]  = res.value[WIDE_W-1:OUT_WIDTH];
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= '0;
      end else if (adv) begin
         out_valid <= &row_tag;
         if (&row_tag) begin
            out_data <= rq_data;
            out_sat  <= rq_sat;
         end
      end
   end

   // Bottom-row pass-through outputs and clamped-away high bits have no consumer.
   logic unused_bits;
   always_comb begin
      unused_bits = ^rq_hi;
      for (int k = 0; k < COLS; k++) unused_bits = unused_bits ^ (^dv[ROWS][k]) ^ vt[ROWS][k];
   end

endmodule
